// File: rtl/blackjack_pkg.sv
// ---------------------------------------------------------------------------
// blackjack_pkg
// Shared definitions for the blackjack controller:
//   - state_t           : FSM state encoding (also driven out on state_o)
//   - ACE, FACE_MIN     : card-value constants
//   - DEFAULT_TARGET    : default bust threshold
//   - DEFAULT_DEALER_STAND : default dealer stand score
//   - card_points()     : maps a 4-bit card code to its hard point value
// ---------------------------------------------------------------------------
package blackjack_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEAL   = 3'd1,
    PLAYER = 3'd2,
    PDRAW  = 3'd3,
    DEALER = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0] ACE      = 4'd1;
  localparam logic [3:0] FACE_MIN = 4'd11;

  localparam int DEFAULT_TARGET       = 21;
  localparam int DEFAULT_DEALER_STAND = 17;

  // Aces count 1 here (the +10 upgrade is applied to the best score).
  // Face cards and the unused codes 0/14/15 are all worth 10.
  function automatic logic [3:0] card_points(input logic [3:0] v);
    if (v == 4'd0 || v >= FACE_MIN) begin
      return 4'd10;
    end
    return v;
  endfunction

endpackage

// File: rtl/blackjack_ctrl_if.sv
// ---------------------------------------------------------------------------
// blackjack_ctrl_if
// Card-source handshake between a card shoe and the blackjack controller.
//   card_valid : shoe has a card on card_value
//   card_value : 4-bit card code (1=ace, 2..10 pips, 11..13 face)
//   card_req   : controller is ready to take a card
// A card moves on a rising edge where card_req and card_valid are both 1.
// Modports: master = card source, slave = controller.
// ---------------------------------------------------------------------------
interface blackjack_ctrl_if;
  logic       card_valid;
  logic [3:0] card_value;
  logic       card_req;

  modport master (output card_valid, output card_value, input card_req);
  modport slave  (input card_valid, input card_value, output card_req);
endinterface

// File: rtl/blackjack_ctrl_hand_acc.sv
// ---------------------------------------------------------------------------
// hand_acc
// Accumulator for one blackjack hand.
//   Clock, resetn : rising-edge clock, asynchronous active-low reset
//   clear         : synchronous clear of the hand (new game)
//   add, value    : take card 'value' into the hand on this edge
//   hard          : hard total (aces = 1), saturating at 2^SCORE_W-1
//   best          : hard+10 when an ace is held and that fits TARGET, else hard
//   count         : cards held, saturating at MAX_CARDS
// ---------------------------------------------------------------------------
module hand_acc
  import blackjack_pkg::*;
#(
  parameter int SCORE_W   = 5,
  parameter int TARGET    = DEFAULT_TARGET,
  parameter int MAX_CARDS = 8,
  parameter int CNT_W     = $clog2(MAX_CARDS + 1)
) (
  input  logic               Clock,
  input  logic               resetn,
  input  logic               clear,
  input  logic               add,
  input  logic [3:0]         value,
  output logic [SCORE_W-1:0] hard,
  output logic [SCORE_W-1:0] best,
  output logic [CNT_W-1:0]   count
);

  localparam logic [SCORE_W:0] HARD_MAX = {1'b0, {SCORE_W{1'b1}}};

  logic [SCORE_W-1:0] hard_reg;
  logic [SCORE_W-1:0] hard_next;
  logic               ace_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [SCORE_W:0]   raw_sum;
  logic [SCORE_W:0]   soft_sum;

  always_comb begin
    // One extra bit so the saturation test sees the carry.
    raw_sum   = {1'b0, hard_reg} + (SCORE_W + 1)'(card_points(value));
    hard_next = (raw_sum > HARD_MAX) ? {SCORE_W{1'b1}} : raw_sum[SCORE_W-1:0];
    soft_sum  = {1'b0, hard_reg} + (SCORE_W + 1)'(10);
    best      = (ace_reg && (soft_sum <= (SCORE_W + 1)'(TARGET)))
                ? soft_sum[SCORE_W-1:0] : hard_reg;
  end

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      hard_reg  <= '0;
      ace_reg   <= 1'b0;
      count_reg <= '0;
    end else if (clear) begin
      hard_reg  <= '0;
      ace_reg   <= 1'b0;
      count_reg <= '0;
    end else if (add) begin
      hard_reg <= hard_next;
      ace_reg  <= ace_reg | (value == ACE);
      if (count_reg != CNT_W'(MAX_CARDS)) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign hard  = hard_reg;
  assign count = count_reg;

endmodule

// File: rtl/blackjack_ctrl.sv
// ---------------------------------------------------------------------------
// blackjack_ctrl
// One-player blackjack game controller: deals, runs the player turn, plays
// the dealer hand up to its stand threshold and resolves the result.
//   Clock, resetn  : rising-edge clock, asynchronous active-low reset
//   start          : begin a game (honoured in IDLE/DONE only)
//   hit, stand     : player decisions (honoured in PLAYER only)
//   card_if        : card handshake (slave side: card_valid/card_value in,
//                    card_req out)
//   player_score   : best player score
//   dealer_score   : best dealer score
//   state_o        : current state code
//   win/lose/push  : result flags, meaningful in DONE
// ---------------------------------------------------------------------------
module blackjack_ctrl
  import blackjack_pkg::*;
#(
  parameter int SCORE_W         = 5,
  parameter int TARGET          = DEFAULT_TARGET,
  parameter int DEALER_STAND    = DEFAULT_DEALER_STAND,
  parameter int DEALER_HIT_SOFT = 0,
  parameter int MAX_CARDS       = 8
) (
  input  logic                 Clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 hit,
  input  logic                 stand,
  blackjack_ctrl_if.slave      card_if,
  output logic [SCORE_W-1:0]   player_score,
  output logic [SCORE_W-1:0]   dealer_score,
  output logic [2:0]           state_o,
  output logic                 win,
  output logic                 lose,
  output logic                 push
);

  localparam int CNT_W = $clog2(MAX_CARDS + 1);

  state_t             state_reg;
  logic [1:0]         deal_cnt_reg;
  logic               card_req_reg;
  logic               win_reg;
  logic               lose_reg;
  logic               push_reg;

  logic               xfer;
  logic               hand_clear;
  logic               add_player;
  logic               add_dealer;
  logic [SCORE_W-1:0] p_hard;
  logic [SCORE_W-1:0] p_best;
  logic [CNT_W-1:0]   p_count;
  logic [SCORE_W-1:0] d_hard;
  logic [SCORE_W-1:0] d_best;
  logic [CNT_W-1:0]   d_count;
  logic [SCORE_W:0]   p_raw_next;
  logic               p_bust_next;
  logic               d_soft;
  logic               d_must_draw;

  assign xfer       = card_req_reg & card_if.card_valid;
  assign hand_clear = start & ((state_reg == IDLE) | (state_reg == DONE));
  // Deal order is player, dealer, player, dealer: even slots go to the player.
  assign add_player = xfer & (((state_reg == DEAL) & ~deal_cnt_reg[0]) |
                              (state_reg == PDRAW));
  assign add_dealer = xfer & (((state_reg == DEAL) & deal_cnt_reg[0]) |
                              (state_reg == DEALER));

  hand_acc #(
    .SCORE_W  (SCORE_W),
    .TARGET   (TARGET),
    .MAX_CARDS(MAX_CARDS),
    .CNT_W    (CNT_W)
  ) u_player (
    .Clock (Clock),
    .resetn(resetn),
    .clear (hand_clear),
    .add   (add_player),
    .value (card_if.card_value),
    .hard  (p_hard),
    .best  (p_best),
    .count (p_count)
  );

  hand_acc #(
    .SCORE_W  (SCORE_W),
    .TARGET   (TARGET),
    .MAX_CARDS(MAX_CARDS),
    .CNT_W    (CNT_W)
  ) u_dealer (
    .Clock (Clock),
    .resetn(resetn),
    .clear (hand_clear),
    .add   (add_dealer),
    .value (card_if.card_value),
    .hard  (d_hard),
    .best  (d_best),
    .count (d_count)
  );

  always_comb begin
    // Bust is judged on the incoming card so PDRAW can go straight to DONE
    // on the transfer edge. Best > TARGET only when hard > TARGET.
    p_raw_next  = {1'b0, p_hard} + (SCORE_W + 1)'(card_points(card_if.card_value));
    p_bust_next = (p_raw_next > (SCORE_W + 1)'(TARGET));
    // A hand is soft exactly when the ace upgrade is in effect.
    d_soft      = (d_best != d_hard);
    d_must_draw = ((d_best < SCORE_W'(DEALER_STAND)) ||
                   ((d_best == SCORE_W'(DEALER_STAND)) && d_soft &&
                    (DEALER_HIT_SOFT != 0))) &&
                  (d_count < CNT_W'(MAX_CARDS));
  end

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= IDLE;
      deal_cnt_reg <= 2'd0;
      card_req_reg <= 1'b0;
      win_reg      <= 1'b0;
      lose_reg     <= 1'b0;
      push_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg    <= DEAL;
            deal_cnt_reg <= 2'd0;
            card_req_reg <= 1'b1;
            win_reg      <= 1'b0;
            lose_reg     <= 1'b0;
            push_reg     <= 1'b0;
          end
        end
        DEAL: begin
          if (xfer) begin
            deal_cnt_reg <= deal_cnt_reg + 2'd1;
            if (deal_cnt_reg == 2'd3) begin
              state_reg    <= PLAYER;
              card_req_reg <= 1'b0;
            end
          end
        end
        PLAYER: begin
          if ((p_best == SCORE_W'(TARGET)) || (p_count == CNT_W'(MAX_CARDS))) begin
            state_reg <= DEALER;
          end else if (stand) begin
            // stand has priority over a simultaneous hit
            state_reg <= DEALER;
          end else if (hit) begin
            state_reg    <= PDRAW;
            card_req_reg <= 1'b1;
          end
        end
        PDRAW: begin
          if (xfer) begin
            card_req_reg <= 1'b0;
            if (p_bust_next) begin
              state_reg <= DONE;
              lose_reg  <= 1'b1;
            end else begin
              state_reg <= PLAYER;
            end
          end
        end
        DEALER: begin
          // After each dealer card, card_req drops for one cycle so the draw
          // decision is re-made on the updated dealer score.
          if (card_req_reg) begin
            if (xfer) begin
              card_req_reg <= 1'b0;
            end
          end else if (d_must_draw) begin
            card_req_reg <= 1'b1;
          end else begin
            state_reg <= DONE;
            if (d_best > SCORE_W'(TARGET)) begin
              win_reg <= 1'b1;
            end else if (p_best > d_best) begin
              win_reg <= 1'b1;
            end else if (p_best < d_best) begin
              lose_reg <= 1'b1;
            end else begin
              push_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          card_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign card_if.card_req = card_req_reg;
  assign player_score     = p_best;
  assign dealer_score     = d_best;
  assign state_o          = state_reg;
  assign win              = win_reg;
  assign lose             = lose_reg;
  assign push             = push_reg;

endmodule

// File: tb/tb_blackjack_ctrl.sv
// ---------------------------------------------------------------------------
// tb_blackjack_ctrl
// Two controllers share one stimulus stream: dut0 with default parameters and
// dut1 with DEALER_HIT_SOFT=1. Each game pushes the expected result for each
// DUT into its queue; a per-DUT monitor pops and compares on entry to DONE.
// ---------------------------------------------------------------------------
module tb_blackjack_ctrl;

  logic       Clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       hit = 1'b0;
  logic       stand = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] card_value = 4'd0;

  logic [4:0] ps0, ds0, ps1, ds1;
  logic [2:0] st0, st1;
  logic       w0, l0, u0, w1, l1, u1;

  typedef struct packed {
    logic [4:0] p;
    logic [4:0] d;
    logic       w;
    logic       l;
    logic       u;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  res_t e0, a0, e1, a1;
  logic [2:0] prev0 = 3'd0;
  logic [2:0] prev1 = 3'd0;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  blackjack_ctrl_if if0();
  blackjack_ctrl_if if1();
  assign if0.card_valid = card_valid;
  assign if0.card_value = card_value;
  assign if1.card_valid = card_valid;
  assign if1.card_value = card_value;

  blackjack_ctrl dut0 (
    .Clock(Clock), .resetn(resetn), .start(start), .hit(hit), .stand(stand),
    .card_if(if0), .player_score(ps0), .dealer_score(ds0), .state_o(st0),
    .win(w0), .lose(l0), .push(u0)
  );

  blackjack_ctrl #(.DEALER_HIT_SOFT(1)) dut1 (
    .Clock(Clock), .resetn(resetn), .start(start), .hit(hit), .stand(stand),
    .card_if(if1), .player_score(ps1), .dealer_score(ds1), .state_o(st1),
    .win(w1), .lose(l1), .push(u1)
  );

  // Result monitors
  always @(negedge Clock) begin
    if (resetn && st0 == 3'd5 && prev0 != 3'd5) begin
      checks++;
      a0 = {ps0, ds0, w0, l0, u0};
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_result: unexpected DONE p=%0d d=%0d w/l/p=%b%b%b", ps0, ds0, w0, l0, u0);
      end else begin
        e0 = q0.pop_front();
        if (a0 !== e0) begin
          errors++;
          $display("FAIL dut0_result: got p=%0d d=%0d w/l/p=%b%b%b required p=%0d d=%0d w/l/p=%b%b%b",
                   a0.p, a0.d, a0.w, a0.l, a0.u, e0.p, e0.d, e0.w, e0.l, e0.u);
        end else begin
          $display("dut0 result p=%0d d=%0d w/l/p=%b%b%b ok", a0.p, a0.d, a0.w, a0.l, a0.u);
        end
      end
    end
    prev0 <= st0;
  end

  always @(negedge Clock) begin
    if (resetn && st1 == 3'd5 && prev1 != 3'd5) begin
      checks++;
      a1 = {ps1, ds1, w1, l1, u1};
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_result: unexpected DONE p=%0d d=%0d w/l/p=%b%b%b", ps1, ds1, w1, l1, u1);
      end else begin
        e1 = q1.pop_front();
        if (a1 !== e1) begin
          errors++;
          $display("FAIL dut1_result: got p=%0d d=%0d w/l/p=%b%b%b required p=%0d d=%0d w/l/p=%b%b%b",
                   a1.p, a1.d, a1.w, a1.l, a1.u, e1.p, e1.d, e1.w, e1.l, e1.u);
        end else begin
          $display("dut1 result p=%0d d=%0d w/l/p=%b%b%b ok", a1.p, a1.d, a1.w, a1.l, a1.u);
        end
      end
    end
    prev1 <= st1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  // Pulse the player/control inputs for one clock, starting at a negedge.
  task automatic pulse(input logic s, input logic h, input logic t);
    start = s;
    hit   = h;
    stand = t;
    @(negedge Clock);
    start = 1'b0;
    hit   = 1'b0;
    stand = 1'b0;
  endtask

  // Offer one card; returns at the negedge just after the transfer edge.
  task automatic give_card(input logic [3:0] v);
    int n;
    n = 0;
    card_valid = 1'b1;
    card_value = v;
    while (!(if0.card_req || if1.card_req) && n < 50) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 50) chk("card_req_timeout", n, 0);
    @(negedge Clock);
    card_valid = 1'b0;
    $display("card %0d offered", v);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!(st0 == 3'd5 && st1 == 3'd5) && n < 60) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 60) chk("done_timeout", n, 0);
    @(negedge Clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    chk("rst_state", st0, 0);
    chk("rst_req", if0.card_req, 0);
    chk("rst_pscore", ps0, 0);
    // Inputs other than start must not move the FSM out of IDLE
    @(negedge Clock);
    resetn = 1'b1;
    hit = 1'b1;
    stand = 1'b1;
    card_valid = 1'b1;
    repeat (3) @(negedge Clock);
    chk("idle_hold_state", st0, 0);
    chk("idle_hold_req", if0.card_req, 0);
    hit = 1'b0;
    stand = 1'b0;
    card_valid = 1'b0;

    // Game 1: player 17 stands, dealer 16 draws 5 -> 21, lose
    q0.push_back('{p: 5'd17, d: 5'd21, w: 1'b0, l: 1'b1, u: 1'b0});
    q1.push_back('{p: 5'd17, d: 5'd21, w: 1'b0, l: 1'b1, u: 1'b0});
    pulse(1, 0, 0);
    give_card(4'd10); give_card(4'd6); give_card(4'd7); give_card(4'd10);
    chk("g1_state_player", st0, 2);
    chk("g1_pscore", ps0, 17);
    chk("g1_dscore", ds0, 16);
    pulse(0, 0, 1);
    give_card(4'd5);
    wait_done();

    // Game 2: ace+king = 21 auto-stands, dealer hard 17, win
    q0.push_back('{p: 5'd21, d: 5'd17, w: 1'b1, l: 1'b0, u: 1'b0});
    q1.push_back('{p: 5'd21, d: 5'd17, w: 1'b1, l: 1'b0, u: 1'b0});
    pulse(1, 0, 0);
    give_card(4'd1); give_card(4'd9); give_card(4'd13); give_card(4'd8);
    wait_done();

    // Game 3: soft 16 hits 10 -> hard 16, hits 9 -> 25 bust
    q0.push_back('{p: 5'd25, d: 5'd19, w: 1'b0, l: 1'b1, u: 1'b0});
    q1.push_back('{p: 5'd25, d: 5'd19, w: 1'b0, l: 1'b1, u: 1'b0});
    pulse(1, 0, 0);
    give_card(4'd1); give_card(4'd10); give_card(4'd5); give_card(4'd9);
    chk("g3_soft16", ps0, 16);
    pulse(0, 1, 0);
    give_card(4'd10);
    chk("g3_hard16", ps0, 16);
    chk("g3_state_player", st0, 2);
    pulse(0, 1, 0);
    give_card(4'd9);
    chk("g3_bust_state", st0, 5);
    repeat (2) @(negedge Clock);
    chk("g3_bust_req", if0.card_req, 0);
    chk("g3_bust_dscore", ds0, 19);

    // Game 4: stalled source in DEAL, then 18 vs 18 push
    q0.push_back('{p: 5'd18, d: 5'd18, w: 1'b0, l: 1'b0, u: 1'b1});
    q1.push_back('{p: 5'd18, d: 5'd18, w: 1'b0, l: 1'b0, u: 1'b1});
    pulse(1, 0, 0);
    repeat (3) @(negedge Clock);
    chk("g4_stall_state", st0, 1);
    chk("g4_stall_pscore", ps0, 0);
    chk("g4_stall_dscore", ds0, 0);
    give_card(4'd10); give_card(4'd10); give_card(4'd8); give_card(4'd8);
    pulse(0, 0, 1);
    wait_done();

    // Game 5: hit+stand acts as stand; reset mid-DEALER
    pulse(1, 0, 0);
    give_card(4'd10); give_card(4'd6); give_card(4'd7); give_card(4'd5);
    pulse(0, 1, 1);
    chk("g5_state_dealer", st0, 4);
    @(negedge Clock);
    chk("g5_pscore_kept", ps0, 17);
    chk("g5_dealer_req", if0.card_req, 1);
    resetn = 1'b0;
    #1;
    chk("g5_rst_state", st0, 0);
    chk("g5_rst_req", if0.card_req, 0);
    chk("g5_rst_pscore", ps0, 0);
    chk("g5_rst_dscore", ds0, 0);
    chk("g5_rst_flags", {w0, l0, u0}, 0);
    chk("g5_rst_state1", st1, 0);
    @(negedge Clock);
    resetn = 1'b1;
    @(negedge Clock);

    // Game 6: dealer soft 17; dut0 stands (win), dut1 draws 3 -> 20 (lose)
    q0.push_back('{p: 5'd18, d: 5'd17, w: 1'b1, l: 1'b0, u: 1'b0});
    q1.push_back('{p: 5'd18, d: 5'd20, w: 1'b0, l: 1'b1, u: 1'b0});
    pulse(1, 0, 0);
    give_card(4'd10); give_card(4'd1); give_card(4'd8); give_card(4'd6);
    chk("g6_dsoft17", ds1, 17);
    pulse(0, 0, 1);
    give_card(4'd3);
    wait_done();

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blackjack_ctrl.md
BLACKJACK_CTRL -- requirements
Module: blackjack_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- SCORE_W, 5, score/total width; SHALL be at least clog2(TARGET+11).
- TARGET, 21, bust threshold; a hand scoring above it is bust.
- DEALER_STAND, 17, the dealer stands at score >= DEALER_STAND.
- DEALER_HIT_SOFT, 0, when 1 the dealer also hits a soft DEALER_STAND.
- MAX_CARDS, 8, per-hand card limit; reaching it forces a stand.

REQ-002 Ports SHALL be, as name, direction, width, meaning (reset resetn, asynchronous, active-low; clock Clock):
- Clock, in, 1, rising-edge clock.
- resetn, in, 1, asynchronous active-low reset.
- start, in, 1, begin a game (IDLE/DONE only).
- hit, in, 1, player requests a card.
- stand, in, 1, player ends turn.
- card_valid, in, 1, card source has a card.
- card_value, in, 4, 1=ace, 2..10 pips, 11..13 face, 0/14/15 invalid.
- card_req, out, 1, controller ready to take a card.
- player_score, out, SCORE_W, best player score.
- dealer_score, out, SCORE_W, best dealer score.
- state_o, out, 3, current state code.
- win, lose, push, out, 1 each, result flags, valid in DONE only.

Function
REQ-003 States and codes SHALL be IDLE=0, DEAL=1, PLAYER=2, PDRAW=3, DEALER=4, DONE=5; codes 6/7 SHALL go to IDLE on the next edge.
REQ-004 A card transfer SHALL occur on an edge where card_req and card_valid are both 1; card_valid without card_req SHALL be ignored.
REQ-005 card_req SHALL be 1 only in DEAL, in PDRAW, and in DEALER while the dealer must draw; it SHALL be registered.
REQ-006 Card value mapping: 11..13 count 10; 0, 14 and 15 SHALL be accepted and count 10.
REQ-007 Each hand SHALL keep a hard total (ace=1), an ace flag and a card count; best score SHALL be hard+10 when an ace is held and hard+10 <= TARGET, otherwise hard.
REQ-008 The hard total SHALL saturate at 2^SCORE_W-1; the card count SHALL saturate at MAX_CARDS.
REQ-009 IDLE/DONE: start SHALL clear both hands and the result flags and enter DEAL.
REQ-010 DEAL: exactly 4 transfers in order player, dealer, player, dealer; then PLAYER.
REQ-011 PLAYER: stand -> DEALER; hit -> PDRAW; hit and stand in the same cycle SHALL be treated as stand.
REQ-012 PLAYER auto-exit: player score == TARGET or card count == MAX_CARDS -> DEALER without any input.
REQ-013 PDRAW: one transfer to the player, then PLAYER; if the player is bust after the transfer -> DONE with lose=1, and the dealer draws nothing.
REQ-014 DEALER: draw while score < DEALER_STAND, or while score == DEALER_STAND and soft and DEALER_HIT_SOFT=1, and card count < MAX_CARDS; otherwise resolve.
REQ-015 Resolve -> DONE, exactly one flag set: dealer bust -> win; otherwise p>d -> win, p<d -> lose, p==d -> push.
REQ-016 Scores SHALL update one cycle after their transfer edge; flags SHALL assert on entry to DONE and hold until start or reset.
REQ-017 start outside IDLE/DONE, and hit/stand outside PLAYER, SHALL be ignored.

Reset
REQ-018 resetn low SHALL immediately force IDLE, card_req=0, both scores=0, all hand registers=0 and win=lose=push=0, from any state including mid-transfer.
REQ-019 After resetn deasserts, the first state change SHALL require start.

Structure
REQ-020 Package blackjack_pkg SHALL hold the state encoding, card-value constants (ACE=1, FACE_MIN=11) and the default TARGET/DEALER_STAND values.
REQ-021 Sub-module hand_acc (hard total, ace flag, count, best score; clear/add inputs) SHALL be instantiated twice, once per hand.

Verification
REQ-022 start; cards 10,6,7,10; stand; card 5 -> player 17, dealer 21, lose=1, state_o=5.
REQ-023 start; cards 1,9,13,8 -> player 21 auto-stand with no stand input, dealer 17 draws none, win=1.
REQ-024 start; cards 1,10,5,9 (player soft 16); hit card 10 -> player 16 hard, not bust, state PLAYER; hit card 9 -> 25, lose=1, card_req stays 0.
REQ-025 card_valid held 0 for 3 cycles in DEAL -> no score change; then cards 10,10,8,8; stand -> push=1, scores 18/18.
REQ-026 hit and stand together in PLAYER -> DEALER, no player card taken; resetn pulse while in DEALER -> IDLE with all outputs 0.
REQ-027 DEALER_HIT_SOFT=1; cards 10,1,8,6 (dealer soft 17); stand -> dealer draws; card 3 -> dealer 20, player 18, lose=1.
